// File: rtl/rc4_feeder_if.sv
// ---------------------------------------------------------------------------
// rc4_feeder_if
//   Groups the host-side write ports, the core request lines and the byte
//   stream outputs of rc4_feeder.  Clock and reset are kept out of it.
//
//   Host / core side drives (master -> slave):
//     CLEAR_IN        synchronous flush
//     KEY_WR_IN       key file write strobe, with KEY_ADDR_IN / KEY_DATA_IN
//     KEY_SIZE_IN     key length in bytes (0 or > depth means full depth)
//     PT_WR_IN        plaintext FIFO push strobe, with PT_DATA_IN
//     PT_LEN_IN       plaintext burst length (0 means 256)
//     KEY_REQ_IN      key-copy request from the core
//     PT_REQ_IN       plaintext request from the core
//   Feeder drives (slave -> master):
//     KEY_BYTE_OUT, PLAIN_BYTE_OUT, PT_VALID_OUT, KEY_BUSY_OUT, PT_BUSY_OUT,
//     PT_FULL_OUT, PT_LEVEL_OUT, OVERFLOW_OUT, UNDERRUN_OUT
// ---------------------------------------------------------------------------
interface rc4_feeder_if #(
  parameter int LW = 6
);
  logic          CLEAR_IN;
  logic          KEY_WR_IN;
  logic [4:0]    KEY_ADDR_IN;
  logic [7:0]    KEY_DATA_IN;
  logic [7:0]    KEY_SIZE_IN;
  logic          PT_WR_IN;
  logic [7:0]    PT_DATA_IN;
  logic [7:0]    PT_LEN_IN;
  logic          KEY_REQ_IN;
  logic          PT_REQ_IN;

  logic [7:0]    KEY_BYTE_OUT;
  logic [7:0]    PLAIN_BYTE_OUT;
  logic          PT_VALID_OUT;
  logic          KEY_BUSY_OUT;
  logic          PT_BUSY_OUT;
  logic          PT_FULL_OUT;
  logic [LW-1:0] PT_LEVEL_OUT;
  logic          OVERFLOW_OUT;
  logic          UNDERRUN_OUT;

  modport master (
    output CLEAR_IN, KEY_WR_IN, KEY_ADDR_IN, KEY_DATA_IN, KEY_SIZE_IN,
           PT_WR_IN, PT_DATA_IN, PT_LEN_IN, KEY_REQ_IN, PT_REQ_IN,
    input  KEY_BYTE_OUT, PLAIN_BYTE_OUT, PT_VALID_OUT, KEY_BUSY_OUT,
           PT_BUSY_OUT, PT_FULL_OUT, PT_LEVEL_OUT, OVERFLOW_OUT, UNDERRUN_OUT
  );

  modport slave (
    input  CLEAR_IN, KEY_WR_IN, KEY_ADDR_IN, KEY_DATA_IN, KEY_SIZE_IN,
           PT_WR_IN, PT_DATA_IN, PT_LEN_IN, KEY_REQ_IN, PT_REQ_IN,
    output KEY_BYTE_OUT, PLAIN_BYTE_OUT, PT_VALID_OUT, KEY_BUSY_OUT,
           PT_BUSY_OUT, PT_FULL_OUT, PT_LEVEL_OUT, OVERFLOW_OUT, UNDERRUN_OUT
  );
endinterface

// File: rtl/rc4_feeder.sv
// ---------------------------------------------------------------------------
// rc4_feeder
//   Upstream stage of the rc4 core.  Holds the key in a host-writable register
//   file and streams it one byte per cycle on a key-copy request; buffers
//   plaintext in a circular FIFO and pops a fixed-length burst, one byte per
//   cycle, on a plaintext request.  The two streams are independent.
//
//   Ports:
//     CLK_IN      clock, all state on rising edge
//     RESET_N_IN  asynchronous active-low reset (clears everything, key file
//                 included)
//     bus         rc4_feeder_if.slave: host writes, core requests, byte
//                 outputs and status (see the interface file)
// ---------------------------------------------------------------------------
module rc4_feeder #(
  parameter int KEY_DEPTH = 32,
  parameter int PT_DEPTH  = 32,
  parameter int LW        = $clog2(PT_DEPTH) + 1
) (
  input  logic        CLK_IN,
  input  logic        RESET_N_IN,
  rc4_feeder_if.slave bus
);
  localparam int              KAW         = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
  localparam int              PAW         = $clog2(PT_DEPTH);
  localparam logic [8:0]      KEY_DEPTH_W = 9'(KEY_DEPTH);
  localparam logic [LW-1:0]   PT_DEPTH_W  = LW'(PT_DEPTH);

  typedef enum logic {K_IDLE, K_SEND} kstate_t;
  typedef enum logic {P_IDLE, P_SEND} pstate_t;

  // ---------------- state ----------------
  logic [7:0]     key_mem_q  [KEY_DEPTH];
  logic [7:0]     fifo_mem_q [PT_DEPTH];

  kstate_t        kstate_q, kstate_d;
  logic [8:0]     kcnt_q, kcnt_d;
  logic [8:0]     klen_q, klen_d;
  logic [7:0]     key_byte_q, key_byte_d;

  pstate_t        pstate_q, pstate_d;
  logic [8:0]     pcnt_q, pcnt_d;
  logic [8:0]     plen_q, plen_d;
  logic [7:0]     plain_byte_q, plain_byte_d;
  logic           pt_valid_q, pt_valid_d;

  logic [PAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           full_q, full_d;
  logic           ovf_q, ovf_d;
  logic           und_q, und_d;

  // ---------------- decoded inputs ----------------
  logic           clear;
  logic [8:0]     key_size_eff;
  logic [8:0]     pt_len_eff;
  logic           key_addr_ok;
  logic           key_wr_en;
  logic           burst_cycle;
  logic           pop;
  logic           push;

  assign clear = bus.CLEAR_IN;

  always_comb begin
    key_size_eff = {1'b0, bus.KEY_SIZE_IN};
    if (bus.KEY_SIZE_IN == 8'd0 || {1'b0, bus.KEY_SIZE_IN} > KEY_DEPTH_W) begin
      key_size_eff = KEY_DEPTH_W;
    end
  end

  assign pt_len_eff  = (bus.PT_LEN_IN == 8'd0) ? 9'd256 : {1'b0, bus.PT_LEN_IN};
  assign key_addr_ok = ({4'b0, bus.KEY_ADDR_IN} < KEY_DEPTH_W);
  // The key file is frozen while a stream reads it, and a flush cycle
  // performs nothing but the flush.
  assign key_wr_en   = bus.KEY_WR_IN && key_addr_ok && (kstate_q == K_IDLE) && !clear;

  // A burst cycle happens every edge in P_SEND and on the accepting edge.
  assign burst_cycle = !clear && ((pstate_q == P_SEND) || bus.PT_REQ_IN);
  assign pop         = burst_cycle && (level_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign push        = !clear && bus.PT_WR_IN && ((level_q != PT_DEPTH_W) || pop);

  // ---------------- key file ----------------
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      for (int i = 0; i < KEY_DEPTH; i++) key_mem_q[i] <= '0;
    end else if (key_wr_en) begin
      key_mem_q[bus.KEY_ADDR_IN[KAW-1:0]] <= bus.KEY_DATA_IN;
    end
  end

  // ---------------- key stream FSM ----------------
  always_comb begin
    kstate_d   = kstate_q;
    kcnt_d     = kcnt_q;
    klen_d     = klen_q;
    key_byte_d = key_byte_q;
    if (clear) begin
      kstate_d = K_IDLE;
      kcnt_d   = '0;
    end else begin
      case (kstate_q)
        K_IDLE: begin
          if (bus.KEY_REQ_IN) begin
            key_byte_d = key_mem_q[0];
            klen_d     = key_size_eff;
            // A one-byte key is finished on the accepting edge.
            if (key_size_eff == 9'd1) begin
              kcnt_d = '0;
            end else begin
              kcnt_d   = 9'd1;
              kstate_d = K_SEND;
            end
          end
        end
        K_SEND: begin
          key_byte_d = key_mem_q[kcnt_q[KAW-1:0]];
          if (kcnt_q == klen_q - 9'd1) begin
            kstate_d = K_IDLE;
            kcnt_d   = '0;
          end else begin
            kcnt_d = kcnt_q + 9'd1;
          end
        end
        default: kstate_d = K_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      kstate_q   <= K_IDLE;
      kcnt_q     <= '0;
      klen_q     <= '0;
      key_byte_q <= '0;
    end else begin
      kstate_q   <= kstate_d;
      kcnt_q     <= kcnt_d;
      klen_q     <= klen_d;
      key_byte_q <= key_byte_d;
    end
  end

  // ---------------- plaintext burst FSM + FIFO control ----------------
  always_comb begin
    pstate_d     = pstate_q;
    pcnt_d       = pcnt_q;
    plen_d       = plen_q;
    plain_byte_d = plain_byte_q;
    pt_valid_d   = 1'b0;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    ovf_d        = ovf_q;
    und_d        = und_q;

    if (clear) begin
      pstate_d = P_IDLE;
      pcnt_d   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      und_d    = 1'b0;
    end else begin
      case (pstate_q)
        P_IDLE: begin
          if (bus.PT_REQ_IN) begin
            plen_d = pt_len_eff;
            if (pt_len_eff == 9'd1) begin
              pcnt_d = '0;
            end else begin
              pcnt_d   = 9'd1;
              pstate_d = P_SEND;
            end
          end
        end
        P_SEND: begin
          if (pcnt_q == plen_q - 9'd1) begin
            pstate_d = P_IDLE;
            pcnt_d   = '0;
          end else begin
            pcnt_d = pcnt_q + 9'd1;
          end
        end
        default: pstate_d = P_IDLE;
      endcase

      // The core's keystream never stalls, so an empty FIFO still uses up
      // a burst cycle and emits a zero byte flagged invalid.
      if (burst_cycle) begin
        if (pop) begin
          plain_byte_d = fifo_mem_q[rd_ptr_q];
          pt_valid_d   = 1'b1;
          rd_ptr_d     = rd_ptr_q + PAW'(1);
        end else begin
          plain_byte_d = 8'h00;
          und_d        = 1'b1;
        end
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PAW'(1);
      end else if (bus.PT_WR_IN) begin
        ovf_d = 1'b1;
      end

      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  assign full_d = (level_d == PT_DEPTH_W);

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      pstate_q     <= P_IDLE;
      pcnt_q       <= '0;
      plen_q       <= '0;
      plain_byte_q <= '0;
      pt_valid_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      pstate_q     <= pstate_d;
      pcnt_q       <= pcnt_d;
      plen_q       <= plen_d;
      plain_byte_q <= plain_byte_d;
      pt_valid_q   <= pt_valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      und_q        <= und_d;
    end
  end

  // FIFO storage carries no reset; only the pointers and level define
  // which entries are meaningful.
  always_ff @(posedge CLK_IN) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bus.PT_DATA_IN;
    end
  end

  // ---------------- outputs ----------------
  assign bus.KEY_BYTE_OUT   = key_byte_q;
  assign bus.PLAIN_BYTE_OUT = plain_byte_q;
  assign bus.PT_VALID_OUT   = pt_valid_q;
  assign bus.KEY_BUSY_OUT   = (kstate_q == K_SEND);
  assign bus.PT_BUSY_OUT    = (pstate_q == P_SEND);
  assign bus.PT_FULL_OUT    = full_q;
  assign bus.PT_LEVEL_OUT   = level_q;
  assign bus.OVERFLOW_OUT   = ovf_q;
  assign bus.UNDERRUN_OUT   = und_q;
endmodule
